uart_tx_fifo: RTL and testbench

//   Parametrised buffered RS-232 transmitter; successor to the fixed-baud single-byte tx path.

---
 rtl/f64_uart_pkg.sv | 9 +
 rtl/uart_sync_fifo.sv | 41 ++++
 rtl/uart_tx_fifo.sv | 106 ++++++++++
 tb/tb_uart_tx_fifo.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/f64_uart_pkg.sv
// f64_uart_pkg: shared types and helpers for the buffered UART transmitter.
package f64_uart_pkg;
    localparam int DATA_BITS_MIN = 5;
    localparam int DATA_BITS_MAX = 9;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
    function automatic int baud_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: power-of-2 synchronous FIFO; dout shows the head entry, valid when !empty.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic wr, rd;
    // full is taken from the registered level, so a push is refused even if a pop happens in the same cycle
    assign wr = push && !full;
    assign rd = pop && !empty;
    assign full = level == LW'(DEPTH);
    assign empty = level == '0;
    assign dout = mem[rd_ptr];
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level <= '0;
        end else begin
            wr_ptr <= wr ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= rd ? rd_ptr + AW'(1) : rd_ptr;
            level <= level + LW'(wr) - LW'(rd);
        end
    end
    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered RS-232 transmitter with baud divider, FIFO and framing FSM.
// Define UART_TX_PARITY_EN to add a parity bit (even, or odd with PARITY_ODD=1).
module uart_tx_fifo import f64_uart_pkg::*; #(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_BITS-1:0]            wr_data,
    input  logic                            wr_en,
    output logic                            full,
    output logic                            empty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] level,
    output logic                            overflow,
    output logic                            busy,
    output logic                            tx
);
    localparam int DIV = baud_div(CLK_HZ, BAUD);
    localparam int CW = $clog2(DIV);
    if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX || STOP_BITS < 1 || STOP_BITS > 2 ||
        DIV < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || PARITY_ODD > 1) begin : g_bad_cfg
        $error("uart_tx_fifo: unsupported parameter set");
    end
    tx_state_t state, state_nxt;
    logic [CW-1:0] cnt;
    logic [3:0] bit_cnt;
    logic [DATA_BITS-1:0] shift, head;
    logic pop, bit_end, last_data, last_stop, tx_nxt;
`ifdef UART_TX_PARITY_EN
    logic par;
`endif
    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .rst(rst), .push(wr_en), .pop(pop), .din(wr_data),
        .dout(head), .full(full), .empty(empty), .level(level)
    );
    assign bit_end = cnt == CW'(DIV - 1);
    assign last_data = bit_end && bit_cnt == 4'(DATA_BITS - 1);
    assign last_stop = bit_end && bit_cnt == 4'(STOP_BITS - 1);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt = state;
        pop = 1'b0;
        tx_nxt = 1'b1;
        case (state)
            IDLE: begin
                pop = !empty;
                state_nxt = empty ? IDLE : START;
            end
            START: begin
                tx_nxt = 1'b0;
                state_nxt = bit_end ? DATA : START;
            end
`ifdef UART_TX_PARITY_EN
            DATA: begin
                tx_nxt = shift[0];
                state_nxt = last_data ? PARITY : DATA;
            end
            PARITY: begin
                tx_nxt = par;
                state_nxt = bit_end ? STOP : PARITY;
            end
`else
            DATA: begin
                tx_nxt = shift[0];
                state_nxt = last_data ? STOP : DATA;
            end
`endif
            STOP: begin
                pop = last_stop && !empty;
                state_nxt = !last_stop ? STOP : empty ? IDLE : START;
            end
            default: state_nxt = IDLE;
        endcase
    end
    // tx and busy are registered; tx trails the state by one clock, which keeps every bit DIV clocks wide
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            bit_cnt <= '0;
            shift <= '0;
            tx <= 1'b1;
            busy <= 1'b0;
            overflow <= 1'b0;
        end else begin
            overflow <= wr_en && full;
            tx <= tx_nxt;
            busy <= state_nxt != IDLE;
            cnt <= (state == IDLE || bit_end) ? '0 : cnt + CW'(1);
            bit_cnt <= !bit_end ? bit_cnt : (state_nxt != state) ? 4'd0 : bit_cnt + 4'd1;
            shift <= pop ? head : (state == DATA && bit_end) ? shift >> 1 : shift;
        end
    end
`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) par <= 1'b0;
        else if (pop) par <= ^head ^ (PARITY_ODD != 0);
    end
`endif
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed scoreboard bench for uart_tx_fifo (DIV=4, 8N1, depth 16).
module tb_uart_tx_fifo;
    localparam int DIV = 4;
    localparam int PODD = 0;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FRAME = (1 + 8 + P + 1) * DIV;

    logic clk = 1'b0;
    logic rst;
    logic [7:0] wr_data;
    logic wr_en;
    logic full, empty, overflow, busy, tx;
    logic [4:0] level;
    int tests = 0;
    int fails = 0;
    logic [7:0] q[$];

    uart_tx_fifo #(
        .CLK_HZ(50000000), .BAUD(12500000), .DATA_BITS(8), .STOP_BITS(1),
        .FIFO_DEPTH(16), .PARITY_ODD(PODD)
    ) dut (
        .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en), .full(full), .empty(empty),
        .level(level), .overflow(overflow), .busy(busy), .tx(tx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Line decoder: samples the middle of every bit and checks against the expected-byte queue
    logic active = 1'b0;
    logic prev_tx = 1'b1;
    int ph = 0;
    int j;
    logic [7:0] sh;
    always @(negedge clk) begin
        if (!rst) begin
            active = 1'b0;
        end else begin
            if (!active && prev_tx && !tx) begin
                active = 1'b1;
                ph = 0;
                sh = '0;
            end else if (active) begin
                ph++;
            end
            if (active && ph % DIV == DIV / 2) begin
                j = ph / DIV;
                if (j == 0) begin
                    check("start_bit", tx, 1'b0);
                end else if (j <= 8) begin
                    sh[j-1] = tx;
`ifdef UART_TX_PARITY_EN
                end else if (j == 9) begin
                    check("parity_bit", tx, ^sh ^ PODD[0]);
`endif
                end else begin
                    check("stop_bit", tx, 1'b1);
                    check("frame_expected", q.size() != 0, 1'b1);
                    if (q.size() != 0) check("frame_data", sh, q.pop_front());
                    active = 1'b0;
                end
            end
        end
        prev_tx = tx;
    end

    // Writes n bytes on consecutive cycles and profiles outputs until busy falls again
    task automatic send(input int n, input logic [7:0] first, input int keep,
                        output int nbusy, output int fbusy, output int flow,
                        output int ffull, output int ovn, output int ovf);
        nbusy = 0; fbusy = -1; flow = -1; ffull = -1; ovn = 0; ovf = -1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (busy) begin
                nbusy++;
                if (fbusy < 0) fbusy = i;
            end
            if (!tx && flow < 0) flow = i;
            if (full && ffull < 0) ffull = i;
            if (overflow) begin
                ovn++;
                if (ovf < 0) ovf = i;
            end
            if (i < n) begin
                wr_en = 1'b1;
                wr_data = first + 8'(i);
                if (i < keep) q.push_back(wr_data);
            end else begin
                wr_en = 1'b0;
                if (nbusy > 0 && !busy) break;
            end
        end
        wr_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int nb, fb, fl, ff, on, of, lows, bz;
        rst = 1'b1;
        wr_en = 1'b0;
        wr_data = '0;
        #3 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {tx, busy, full, empty, level, overflow}, {1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0});
        rst = 1'b1;
        // idle line
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle", {tx, busy, empty, level, overflow}, {1'b1, 1'b0, 1'b1, 5'd0, 1'b0});
        end
        // single frame of 0x59
        send(1, 8'h59, 1, nb, fb, fl, ff, on, of);
        check("t2_busy_len", nb, FRAME);
        check("t2_pop_cycle", fb, 2);
        check("t2_tx_fall", fl, 3);
        check("t2_no_overflow", on, 0);
        check("t2_never_full", ff, -1);
        check("t2_drained", q.size(), 0);
        check("t2_end_state", {tx, empty, level}, {1'b1, 1'b1, 5'd0});
        repeat (5) @(negedge clk);
        // three back-to-back frames
        send(3, 8'h41, 3, nb, fb, fl, ff, on, of);
        check("t3_busy_len", nb, 3 * FRAME);
        check("t3_pop_cycle", fb, 2);
        check("t3_drained", q.size(), 0);
        check("t3_end_state", {tx, empty, busy}, {1'b1, 1'b1, 1'b0});
        repeat (5) @(negedge clk);
        // overflow: 18 writes, the last one is dropped
        send(18, 8'h80, 17, nb, fb, fl, ff, on, of);
        check("t4_pop_cycle", fb, 2);
        check("t4_full_cycle", ff, 17);
        check("t4_overflow_count", on, 1);
        check("t4_overflow_cycle", of, 18);
        check("t4_busy_len", nb, 17 * FRAME);
        check("t4_drained", q.size(), 0);
        check("t4_end_state", {empty, full, level}, {1'b1, 1'b0, 5'd0});
        repeat (5) @(negedge clk);
        // reset during the third data bit of the first of four queued frames
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            wr_en = 1'b1;
            wr_data = 8'hC4 + 8'(i);
            q.push_back(wr_data);
        end
        @(negedge clk);
        wr_en = 1'b0;
        repeat (12) @(negedge clk);
        check("t6_pre_reset", {busy, level}, {1'b1, 5'd3});
        #2 rst = 1'b0;
        #1;
        check("t6_reset_async", {tx, busy, empty, full, level, overflow}, {1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0});
        q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        lows = 0;
        bz = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!tx) lows++;
            if (busy) bz++;
        end
        check("t6_no_tx_after_reset", lows, 0);
        check("t6_no_busy_after_reset", bz, 0);
        check("t6_level_after_reset", level, 5'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
